flags: RTL and testbench



---
 rtl/flags_pkg.sv | 22 ++
 rtl/flags.sv | 61 ++++++
 tb/tb_flags.sv | 136 +++++++++++++
 3 files changed

// File: rtl/flags_pkg.sv
// Shared CPU package: flag-vector width, flag bit positions and a packing helper.
//   FLAG_W  : number of status flags in the packed flag vector
//   FLAG_Z  : bit index of the zero flag
//   FLAG_C  : bit index of the carry flag
package flags_pkg;

   localparam int unsigned FLAG_W = 2;
   localparam int unsigned FLAG_Z = 0;
   localparam int unsigned FLAG_C = 1;

   typedef logic [FLAG_W-1:0] flag_vec_t;

   // Place individual flag bits at their architectural positions.
   function automatic flag_vec_t pack_flags(input logic z, input logic c);
      flag_vec_t v;
      v         = '0;
      v[FLAG_Z] = z;
      v[FLAG_C] = c;
      return v;
   endfunction

endpackage : flags_pkg

// File: rtl/flags.sv
// ALU status register: captures zero/carry on an enabled rising edge, holds otherwise.
// Parameters:
//   ZERO_RST   : value of zero_out after reset
//   CARRY_RST  : value of carry_out after reset
// Ports:
//   clk        in  : rising-edge clock
//   reset      in  : synchronous, active-low reset (sampled on clk)
//   enable     in  : load strobe, both flags load together
//   zero       in  : ALU zero result
//   carry      in  : ALU carry-out result
//   zero_out   out : registered zero flag
//   carry_out  out : registered carry flag
module flags
   import flags_pkg::*;
#(
   parameter logic ZERO_RST  = 1'b0,
   parameter logic CARRY_RST = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic zero,
   input  logic carry,
   output logic zero_out,
   output logic carry_out
);

   localparam flag_vec_t RST_VEC = pack_flags(ZERO_RST, CARRY_RST);

   flag_vec_t flag_q;
   flag_vec_t load_vec;

   // Incoming ALU results arranged as a flag vector.
   always_comb begin
      load_vec = pack_flags(zero, carry);
   end

   // Flag register: reset has priority over load; otherwise hold.
   always_ff @(posedge clk) begin
      if (!reset) begin
         flag_q <= RST_VEC;
      end else if (enable) begin
         flag_q <= load_vec;
      end
   end

   // Outputs come straight from the flops.
   assign zero_out  = flag_q[FLAG_Z];
   assign carry_out = flag_q[FLAG_C];

`ifndef SYNTHESIS
   // Reset edge forces both flags to their reset values.
   a_reset_value : assert property (@(posedge clk)
      !reset |=> (zero_out == ZERO_RST) && (carry_out == CARRY_RST));

   // Idle edge (not reset, not enabled) leaves both flags untouched.
   a_hold : assert property (@(posedge clk)
      (reset && !enable) |=> ($stable(zero_out) && $stable(carry_out)));
`endif

endmodule : flags

// File: tb/tb_flags.sv
// Self-checking bench for flags: directed steps followed by random traffic,
// compared against a rule-level reference model for two parameterisations.
module tb_flags;

   logic clk = 1'b0;
   logic reset;
   logic enable;
   logic zero;
   logic carry;
   logic zero_out_a, carry_out_a;
   logic zero_out_b, carry_out_b;

   int checks = 0;
   int passed = 0;

   // Reference model state: index 0 = default params, index 1 = reset values 1/1.
   logic exp_z [2];
   logic exp_c [2];
   logic rst_z [2] = '{1'b0, 1'b1};
   logic rst_c [2] = '{1'b0, 1'b1};

   always #5 clk = ~clk;

   flags u_dut_a (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .zero      (zero),
      .carry     (carry),
      .zero_out  (zero_out_a),
      .carry_out (carry_out_a)
   );

   flags #(
      .ZERO_RST  (1'b1),
      .CARRY_RST (1'b1)
   ) u_dut_b (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .zero      (zero),
      .carry     (carry),
      .zero_out  (zero_out_b),
      .carry_out (carry_out_b)
   );

   task automatic chk(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) passed++;
      else $error("FAIL %s: got %b, expected %b", tag, got, exp);
   endtask

   task automatic chk_all(input string tag);
      chk({tag, " a.zero"},  zero_out_a,  exp_z[0]);
      chk({tag, " a.carry"}, carry_out_a, exp_c[0]);
      chk({tag, " b.zero"},  zero_out_b,  exp_z[1]);
      chk({tag, " b.carry"}, carry_out_b, exp_c[1]);
   endtask

   // Apply inputs away from the edge, clock once, advance the model, check.
   task automatic step(input string tag, input logic r, input logic e,
                       input logic z, input logic c);
      @(negedge clk);
      reset  = r;
      enable = e;
      zero   = z;
      carry  = c;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (r == 1'b0) begin
            exp_z[k] = rst_z[k];
            exp_c[k] = rst_c[k];
         end else if (e == 1'b1) begin
            exp_z[k] = z;
            exp_c[k] = c;
         end
      end
      #1;
      chk_all(tag);
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      zero   = 1'b0;
      carry  = 1'b0;

      // Reset wins even with enable and data all high.
      step("reset", 1'b0, 1'b1, 1'b1, 1'b1);

      // Hold: toggling data with enable low changes nothing.
      step("hold0", 1'b1, 1'b0, 1'b1, 1'b0);
      step("hold1", 1'b1, 1'b0, 1'b0, 1'b1);
      step("hold2", 1'b1, 1'b0, 1'b1, 1'b1);

      // Load zero=1 carry=0, then carry=1.
      step("load_z", 1'b1, 1'b1, 1'b1, 1'b0);
      step("load_c", 1'b1, 1'b1, 1'b1, 1'b1);

      // Between edges: carry dips mid-cycle, restored before the edge.
      @(negedge clk);
      enable = 1'b1;
      zero   = 1'b0;
      carry  = 1'b1;
      #2 carry = 1'b0;
      #1;
      chk_all("midcycle");
      carry = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         exp_z[k] = 1'b0;
         exp_c[k] = 1'b1;
      end
      #1;
      chk_all("edge_capture");

      // Priority: flags at 1/1, then reset together with enable.
      step("set11", 1'b1, 1'b1, 1'b1, 1'b1);
      step("prio",  1'b0, 1'b1, 1'b1, 1'b1);

      // Retention: load 0/1, drop enable, vary inputs for 4 cycles.
      step("ret_load", 1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step("retain", 1'b1, 1'b0, 1'(i), 1'(i >> 1));
      end

      // Random traffic; reset asserted occasionally.
      for (int i = 0; i < 300; i++) begin
         step("random", ($urandom_range(15) != 0), 1'($urandom), 1'($urandom), 1'($urandom));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule : tb_flags
